// File: rtl/axi_cpwm_regs_core_if.sv
//============================================================================
// Module  : axi_cpwm_regs_core_if
// Brief   : AXI4-Lite bundle for the CPWM register block (master/slave views)
// Revision: 1.0
//============================================================================
`default_nettype none

interface axi_cpwm_regs_core_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

`default_nettype wire

// File: rtl/axi_cpwm_regs_core.sv
//============================================================================
// Module  : axi_cpwm_regs_core
// Brief   : AXI4-Lite CPWM registers + carrier PWM with shadowing and dead time
// Revision: 1.0
//============================================================================
`default_nettype none

module axi_cpwm_regs_core #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_CNT_WIDTH        = 16
) (
    input  wire logic           S_AXI_ACLK,
    input  wire logic           S_AXI_ARESETN,
    axi_cpwm_regs_core_if.slave s_axi,
    output logic                pwm_h,
    output logic                pwm_l,
    output logic                carrier_zero
);

    localparam int c_ADDR_LSB = 2;
    localparam int c_NBYTES   = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        S_UP   = 1'b0,
        S_DOWN = 1'b1
    } dir_t;

    // ---------------- register file and AXI handshakes ----------------
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
    logic                          r_awready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic       w_wr_en;
    logic       w_rd_en;
    logic [1:0] w_waddr;
    logic [1:0] w_raddr;
    logic       w_unused;

    assign w_wr_en = r_awready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign w_rd_en = r_arready && s_axi.S_AXI_ARVALID;
    assign w_waddr = s_axi.S_AXI_AWADDR[c_ADDR_LSB +: 2];
    assign w_raddr = s_axi.S_AXI_ARADDR[c_ADDR_LSB +: 2];
    assign w_unused = &{1'b0, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[c_ADDR_LSB-1:0],
                        s_axi.S_AXI_ARADDR[c_ADDR_LSB-1:0]};

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_awready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RDATA   = r_rdata;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    // Both write channels are accepted together; the early one simply waits.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_awready <= !r_awready && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !r_bvalid;
            if (w_wr_en) begin
                for (int b = 0; b < c_NBYTES; b++) begin
                    if (s_axi.S_AXI_WSTRB[b]) begin
                        r_regs[w_waddr][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
                    end
                end
                r_bvalid <= 1'b1;
            end else if (s_axi.S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= !r_arready && s_axi.S_AXI_ARVALID && !r_rvalid;
            if (w_rd_en) begin
                r_rdata  <= r_regs[w_raddr];
                r_rvalid <= 1'b1;
            end else if (s_axi.S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- carrier generator ----------------
    logic                   w_en;
    logic                   w_mode;
    logic [C_CNT_WIDTH-1:0] w_period;
    logic [C_CNT_WIDTH-1:0] w_compare;
    logic [C_CNT_WIDTH-1:0] w_deadtime;

    assign w_en       = r_regs[0][0];
    assign w_mode     = r_regs[0][1];
    assign w_period   = r_regs[1][C_CNT_WIDTH-1:0];
    assign w_compare  = r_regs[2][C_CNT_WIDTH-1:0];
    assign w_deadtime = r_regs[3][C_CNT_WIDTH-1:0];

    logic [C_CNT_WIDTH-1:0] r_cnt;
    logic [C_CNT_WIDTH-1:0] w_cnt_nxt;
    dir_t                   r_dir;
    dir_t                   w_dir_nxt;
    logic [C_CNT_WIDTH-1:0] r_per_sh;
    logic [C_CNT_WIDTH-1:0] r_cmp_sh;
    logic [C_CNT_WIDTH-1:0] w_per_eff;
    logic                   w_at_zero;

    assign w_at_zero = (r_cnt == '0);
    // On the zero cycle the shadow is being reloaded, so look ahead at the new period.
    assign w_per_eff = w_at_zero ? w_period : r_per_sh;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (!w_en) begin
            w_cnt_nxt = '0;
            w_dir_nxt = S_UP;
        end else if (!w_mode) begin
            w_dir_nxt = S_UP;
            w_cnt_nxt = (r_cnt >= w_per_eff) ? '0 : r_cnt + C_CNT_WIDTH'(1);
        end else begin
            case (r_dir)
                S_UP: begin
                    if (r_cnt >= w_per_eff) begin
                        if (w_per_eff == '0) begin
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt - C_CNT_WIDTH'(1);
                            w_dir_nxt = S_DOWN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_WIDTH'(1);
                    end
                end
                S_DOWN: begin
                    if (w_at_zero) begin
                        w_dir_nxt = S_UP;
                    end else begin
                        w_cnt_nxt = r_cnt - C_CNT_WIDTH'(1);
                        if (r_cnt == C_CNT_WIDTH'(1)) begin
                            w_dir_nxt = S_UP;
                        end
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                    w_dir_nxt = S_UP;
                end
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_cnt    <= '0;
            r_dir    <= S_UP;
            r_per_sh <= '0;
            r_cmp_sh <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
            if (!w_en || w_at_zero) begin
                r_per_sh <= w_period;
                r_cmp_sh <= w_compare;
            end
        end
    end

    assign carrier_zero = w_en && w_at_zero;

    // ---------------- reference and dead-time insertion ----------------
    logic                   w_ref;
    logic                   r_ref_q;
    logic [C_CNT_WIDTH-1:0] r_dt_cnt;
    logic [C_CNT_WIDTH-1:0] w_dt_nxt;
    logic                   r_pwm_h;
    logic                   r_pwm_l;

    assign w_ref = w_en && (r_cnt < r_cmp_sh);

    always_comb begin
        w_dt_nxt = '0;
        if (!w_en) begin
            w_dt_nxt = '0;
        end else if (w_ref != r_ref_q) begin
            w_dt_nxt = w_deadtime;
        end else if (r_dt_cnt != '0) begin
            w_dt_nxt = r_dt_cnt - C_CNT_WIDTH'(1);
        end
    end

    // Gates open only once the dead-time count has drained, so both sides can never be on.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_ref_q  <= 1'b0;
            r_dt_cnt <= '0;
            r_pwm_h  <= 1'b0;
            r_pwm_l  <= 1'b0;
        end else begin
            r_ref_q  <= w_ref;
            r_dt_cnt <= w_dt_nxt;
            r_pwm_h  <= w_en && w_ref && (w_dt_nxt == '0);
            r_pwm_l  <= w_en && !w_ref && (w_dt_nxt == '0);
        end
    end

    assign pwm_h = r_pwm_h;
    assign pwm_l = r_pwm_l;

endmodule

`default_nettype wire
